// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Board clock and debounce window set the default qualification length.
package switch_debouncer_pkg;

   localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
   localparam int unsigned DEBOUNCE_MS         = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
   localparam int unsigned CNT_W_DEF           = 20;

   // Registered per-channel result: accepted level plus one-cycle edge pulses.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } db_out_t;

endpackage

// File: rtl/switch_debouncer_bit.sv
// One debounce channel: 2-flop synchroniser, persistence counter, accepted
// level and registered rise/fall pulses.
module debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic    Clk,
   input  logic    Reset_n,
   input  logic    sw_i,
   output db_out_t out_o,
   output logic    accept_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             state_q, state_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample matching the accepted level restarts qualification.
   always_comb begin
      cnt_d    = '0;
      state_d  = state_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      accept_o = 1'b0;
      if (sync2_q != state_q) begin
         if (cnt_q == CNT_MAX) begin
            accept_o = 1'b1;
            state_d  = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign out_o = '{level: state_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH independent debounce channels plus a registered any-event flag.
// AnyEvent registers the channels' accept strobes so it aligns with the pulses.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] SlideSwitch,
   output logic [WIDTH-1:0] SwitchState,
   output logic [WIDTH-1:0] RiseEvent,
   output logic [WIDTH-1:0] FallEvent,
   output logic             AnyEvent
);

   db_out_t [WIDTH-1:0] ch;
   logic    [WIDTH-1:0] accept;
   logic                any_q, any_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .Clk      (Clk),
         .Reset_n  (Reset_n),
         .sw_i     (SlideSwitch[g]),
         .out_o    (ch[g]),
         .accept_o (accept[g])
      );
      assign SwitchState[g] = ch[g].level;
      assign RiseEvent[g]   = ch[g].rise;
      assign FallEvent[g]   = ch[g].fall;
   end

   assign any_d = |accept;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) any_q <= 1'b0;
      else          any_q <= any_d;
   end

   assign AnyEvent = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and random stimulus for switch_debouncer, checked every cycle
// against a sliding-window model of the acceptance rule.
module tb_switch_debouncer;

   localparam int W  = 4;
   localparam int DC = 4;
   localparam int CW = 3;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic [W-1:0] SlideSwitch = '0;
   logic [W-1:0] SwitchState, RiseEvent, FallEvent;
   logic         AnyEvent;

   switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .SlideSwitch (SlideSwitch),
      .SwitchState (SwitchState),
      .RiseEvent   (RiseEvent),
      .FallEvent   (FallEvent),
      .AnyEvent    (AnyEvent)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_fail = 0;

   // hist holds the pin value sampled at every edge since reset, preceded by
   // the two zero sync-flop values; sync2 seen at an edge is three entries back.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_state, m_rise, m_fall;
   logic         m_any;

   // Per-hold observations of the DUT.
   int rise_at[W], fall_at[W], rise_n[W], fall_n[W];
   int any_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_state = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
   endfunction

   // A bit flips once its last DC sync2 samples all disagree with it.
   function automatic void model_edge();
      logic [W-1:0] acc;
      logic [W-1:0] s;
      int sz;
      acc = '0;
      sz  = hist.size();
      if (sz - 2 >= DC) begin
         for (int b = 0; b < W; b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++) begin
               s = hist[sz-3-k];
               if (s[b] == m_state[b]) all_diff = 1'b0;
            end
            acc[b] = all_diff;
         end
      end
      m_rise  = acc & ~m_state;
      m_fall  = acc & m_state;
      m_state = m_state ^ acc;
      m_any   = |acc;
   endfunction

   task automatic step();
      @(posedge Clk);
      hist.push_back(SlideSwitch);
      #1;
      model_edge();
      check("state", SwitchState, m_state);
      check("rise",  RiseEvent,   m_rise);
      check("fall",  FallEvent,   m_fall);
      check("any",   AnyEvent,    m_any);
   endtask

   task automatic hold(input logic [W-1:0] v, input int n);
      SlideSwitch = v;
      any_n = 0;
      for (int b = 0; b < W; b++) begin
         rise_at[b] = -1; fall_at[b] = -1; rise_n[b] = 0; fall_n[b] = 0;
      end
      for (int k = 0; k < n; k++) begin
         step();
         if (AnyEvent) any_n++;
         for (int b = 0; b < W; b++) begin
            if (RiseEvent[b]) begin rise_n[b]++; if (rise_at[b] < 0) rise_at[b] = k; end
            if (FallEvent[b]) begin fall_n[b]++; if (fall_at[b] < 0) fall_at[b] = k; end
         end
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      model_reset();
      #3;
      check("rst_state", SwitchState, 0);
      check("rst_rise",  RiseEvent,   0);
      check("rst_fall",  FallEvent,   0);
      check("rst_any",   AnyEvent,    0);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      // Switches already high through reset are reported as rises.
      SlideSwitch = 4'hF;
      do_reset();
      hold(4'hF, 8);
      for (int b = 0; b < W; b++) check("init_rise_at", rise_at[b], 5);
      check("init_any_n", any_n, 1);

      // Clean press and release on bit 0.
      hold(4'h0, 8);
      hold(4'h1, 8);
      check("press_rise_at", rise_at[0], 5);
      check("press_rise_n",  rise_n[0], 1);
      check("press_fall_n",  fall_n[0], 0);
      hold(4'h0, 8);
      check("release_fall_at", fall_at[0], 5);
      check("release_fall_n",  fall_n[0], 1);

      // Bounce on bit 1, then settle high.
      hold(4'h0, 8);
      hold(4'h2, 2); hold(4'h0, 2); hold(4'h2, 2); hold(4'h0, 2);
      hold(4'h2, 10);
      check("bounce_rise_at", rise_at[1], 5);
      check("bounce_rise_n",  rise_n[1], 1);

      // Simultaneous rise and fall.
      hold(4'h0, 8);
      hold(4'h8, 8);
      hold(4'h4, 8);
      check("simul_rise_at", rise_at[2], 5);
      check("simul_fall_at", fall_at[3], 5);
      check("simul_any_n",   any_n, 1);

      // Reset during qualification discards the partial count.
      hold(4'h0, 8);
      hold(4'h1, 3);
      do_reset();
      hold(4'h1, 8);
      check("midrst_rise_at", rise_at[0], 5);

      // Single-cycle glitch on bit 2.
      hold(4'h0, 8);
      hold(4'h4, 1);
      check("glitch_any_a", any_n, 0);
      hold(4'h0, 10);
      check("glitch_any_b", any_n, 0);

      // Random hold lengths around the qualification window, occasional reset.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         hold(W'($urandom), int'($urandom_range(1, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
